// File: rtl/cmp_arb_pkg.sv
// Shared constants, state type and round-robin helper for cmp_share_arb.
// Optional signed compare is selected with CMP_SIGNED_EN (see mag_cmp).
package cmp_arb_pkg;

    localparam logic [2:0] RES_EQ = 3'b001;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // First valid index at or after ptr, wrapping at n (n <= 8).
    function automatic logic [2:0] next_rr(
        input logic [2:0] ptr,
        input logic [7:0] valid,
        input int         n
    );
        logic [2:0] g;
        logic       found;
        int         idx;
        g     = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && i < n && valid[idx]) begin
                g     = 3'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mag_cmp.sv
// Single shared magnitude comparator, one-hot {lt,gt,eq} result.
// CMP_SIGNED_EN selects two's-complement compare; default is unsigned.
module mag_cmp
    import cmp_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       res
);

    logic lt;
    logic gt;

    always_comb begin
`ifdef CMP_SIGNED_EN
        lt = $signed(a) < $signed(b);
        gt = $signed(a) > $signed(b);
`else
        lt = a < b;
        gt = a > b;
`endif
        if (lt)
            res = RES_LT;
        else if (gt)
            res = RES_GT;
        else
            res = RES_EQ;
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sequencing NREQ requesters onto one comparator.
// Build with CMP_SIGNED_EN defined for signed operand compare.
module cmp_share_arb
    import cmp_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2:0]            rsp_res,
    output logic                  busy
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       res_c;
    logic [7:0]       vext;
    logic             any_v;

    assign vext  = 8'(req_valid);
    assign any_v = |req_valid;
    assign grant = IDW'(next_rr(3'(rr_ptr), vext, NREQ));

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_v)
            req_ready[grant] = 1'b1;
    end

    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a   (op_a),
        .b   (op_b),
        .res (res_c)
    );

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = cur_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            cur_id  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            rsp_res <= 3'b000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_v) begin
                        op_a   <= req_a[int'(grant)*WIDTH +: WIDTH];
                        op_b   <= req_b[int'(grant)*WIDTH +: WIDTH];
                        cur_id <= grant;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    rsp_res <= res_c;
                    state   <= RESP;
                end
                RESP: begin
                    // Pointer moves only once the result has been taken.
                    if (rsp_ready) begin
                        if (cur_id == IDW'(NREQ - 1))
                            rr_ptr <= '0;
                        else
                            rr_ptr <= cur_id + 1'b1;
                        rsp_res <= 3'b000;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb with a response scoreboard.
// Expected {id,res} pairs are queued at drive time, popped on handshake.
module tb_cmp_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2:0]            rsp_res;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;
    int rr_seen = 0;
    bit rr_phase = 0;
    int acc;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2:0]     res;
    } exp_t;

    exp_t q[$];
    exp_t e;

    cmp_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
`ifdef CMP_SIGNED_EN
        if ($signed(a) < $signed(b)) return 3'b100;
        if ($signed(a) > $signed(b)) return 3'b010;
`else
        if (a < b) return 3'b100;
        if (a > b) return 3'b010;
`endif
        return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input int id, input logic [3:0] a, input logic [3:0] b);
        exp_t x;
        x.id  = IDW'(id);
        x.res = model(a, b);
        q.push_back(x);
    endtask

    task automatic one_req(input int id, input logic [3:0] a, input logic [3:0] b);
        set_req(id, a, b);
        req_valid = NREQ'(1) << id;
        rsp_ready = 1'b1;
        push(id, a, b);
        #1;
        chk("accept_ready", 32'(req_ready), 32'(NREQ'(1) << id));
        tk();
        req_valid = '0;
        set_req(id, ~a, ~b);
        chk("cmp_busy", 32'(busy), 32'(1));
        chk("cmp_novalid", 32'(rsp_valid), 32'(0));
        tk();
        chk("resp_valid", 32'(rsp_valid), 32'(1));
        chk("resp_id", 32'(rsp_id), 32'(id));
        tk();
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    // Scoreboard: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected", 32'(1), 32'(0));
            end else begin
                e = q.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e.id));
                chk("sb_res", 32'(rsp_res), 32'(e.res));
            end
            if (rr_phase) begin
                if (rr_seen > 0)
                    chk("rr_gap", 32'(cyc - last_hs), 32'(3));
                last_hs = cyc;
                rr_seen++;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) tk();
        rst_n = 1'b1;
        tk();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_res", 32'(rsp_res), 32'(0));

        one_req(0, 4'b0001, 4'b0010);
        one_req(2, 4'b0110, 4'b0110);

        // Reset while a result is waiting in RESP.
        set_req(1, 4'b1001, 4'b0100);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        push(1, 4'b1001, 4'b0100);
        #1;
        chk("mid_accept", 32'(req_ready), 32'(4'b0010));
        tk();
        req_valid = '0;
        tk();
        chk("mid_resp_valid", 32'(rsp_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_drop", 32'(rsp_valid), 32'(0));
        chk("mid_async_busy", 32'(busy), 32'(0));
        q.delete();
        tk();
        rst_n = 1'b1;

        // All requesters valid: expect grants 0,1,2,3,0 three cycles apart.
        rr_phase = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'b0011, 4'b1000);
        req_valid = '1;
        rsp_ready = 1'b1;
        push(0, 4'b0011, 4'b1000);
        push(1, 4'b0011, 4'b1000);
        push(2, 4'b0011, 4'b1000);
        push(3, 4'b0011, 4'b1000);
        push(0, 4'b0011, 4'b1000);
        #1;
        chk("rst_grant0", 32'(req_ready), 32'(4'b0001));
        acc = 0;
        for (int c = 0; c < 60 && acc < 5; c++) begin
            if (|req_ready) acc++;
            tk();
            #1;
        end
        req_valid = '0;
        chk("rr_accepts", 32'(acc), 32'(5));
        for (int c = 0; c < 30 && q.size() != 0; c++) tk();
        chk("rr_drain", 32'(q.size()), 32'(0));
        chk("rr_count", 32'(rr_seen), 32'(5));
        rr_phase = 0;
        tk();

        // Backpressure on req1 with req2 also pending.
        set_req(1, 4'b0110, 4'b0010);
        set_req(2, 4'b0101, 4'b0101);
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        push(1, 4'b0110, 4'b0010);
        push(2, 4'b0101, 4'b0101);
        #1;
        chk("bp_accept1", 32'(req_ready), 32'(4'b0010));
        tk();
        tk();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_res", 32'(rsp_res), 32'(3'b010));
            chk("bp_ready0", 32'(req_ready), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
            tk();
        end
        rsp_ready = 1'b1;
        tk();
        chk("bp_next_grant", 32'(req_ready), 32'(4'b0100));
        tk();
        req_valid = '0;
        for (int c = 0; c < 20 && q.size() != 0; c++) tk();
        chk("bp_drain", 32'(q.size()), 32'(0));
        tk();
        chk("end_idle", 32'(busy), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_share_arb.md
Name: cmp_share_arb

Overview:
- Round-robin arbiter and sequencer sharing one magnitude comparator among NREQ requesters.
- Each requester presents an operand pair under a valid/ready handshake. The block grants one requester, runs the compare, and returns a one-hot {lt,gt,eq} result tagged with the requester ID.
- Sits between lab datapath clients and the single comparator instance, so only one comparator is built.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  IDW  ID of the requester that owns the result.
- rsp_res  out  3  result: bit0 = a==b, bit1 = a>b, bit2 = a<b; exactly one bit set when valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE: if any req_valid, grant the first valid requester at or after rr_ptr, searching upward with wrap. req_ready[grant] is high combinationally in this cycle; all other req_ready bits are 0. On the clock edge, latch op_a, op_b and cur_id, then go to CMP. If no request is valid, stay in IDLE with req_ready all 0.
  - CMP: mag_cmp evaluates the latched operands. Its result is registered into rsp_res, and the state goes to RESP.
  - RESP: rsp_valid=1. rsp_id, rsp_res, op_a and op_b are held stable until rsp_ready. On the edge where rsp_valid&&rsp_ready, set rr_ptr = cur_id+1 (mod NREQ) and go to IDLE.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid rises after edge N+1; the earliest response handshake is at edge N+2.
  - Sustained throughput is one compare per 3 cycles when rsp_ready is held high.
  - No new request is accepted before the previous response handshake.
- Fairness:
  - The pointer advances only after a completed response.
  - A requester holding valid continuously is served at most once per NREQ grants while others are pending.
- Requester rules:
  - req_valid may drop without a handshake, and operands may change while not ready; no error is flagged.
  - Once the handshake completes, later changes on req_a/req_b do not affect the captured operands.
- Simultaneous events: when all requesters are valid with rr_ptr=k, grant order is k, k+1, …, wrapping.
- rsp_ready high outside RESP is ignored.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_res=3'b000, req_ready=0, busy=0, latched operands=0.
- Reset mid-operation: asserting rst_n low in CMP or RESP drops rsp_valid immediately (asynchronously). The in-flight result is discarded and not replayed.
- Arithmetic:
  - Comparison is unsigned over WIDTH bits.
  - The result is one-hot; rsp_res=3'b000 appears only outside RESP.

Optional Feature:
- CMP_SIGNED_EN defined: operands are compared as WIDTH-bit two's complement (e.g. 4'b1000 < 4'b0001, rsp_res=3'b100).
- CMP_SIGNED_EN undefined: unsigned compare (4'b1000 > 4'b0001, rsp_res=3'b010).
- No other behaviour changes.

Decomposition:
- Package cmp_arb_pkg:
  - Result constants RES_EQ=3'b001, RES_GT=3'b010, RES_LT=3'b100.
  - State enum typedef {IDLE, CMP, RESP}.
  - Function next_rr(ptr, valid) returning the granted index.
- Sub-module mag_cmp:
  - Parameterised by WIDTH; purely combinational, with the same 3-bit encoding as rsp_res.
  - It is the only comparator instance.
  - CMP_SIGNED_EN is honoured inside mag_cmp.

Test Plan:
- Reset: hold rst_n=0, then release with all req_valid=0 -> rsp_valid=0, req_ready=0, busy=0, rsp_res=3'b000.
- Single request, operands: req0 a=4'b0001, b=4'b0010, rsp_ready=1.
  - Expect req_ready=4'b0001 in the accept cycle.
  - Expect rsp_valid 2 cycles later with rsp_id=0, rsp_res=3'b100.
- Single request, equal operands: req2 a=4'b0110, b=4'b0110 -> rsp_id=2, rsp_res=3'b001.
- Round-robin: all 4 valid continuously with a=4'b0011, b=4'b1000, rsp_ready=1.
  - Grants in order 0,1,2,3,0.
  - Each response has rsp_res=3'b100 (unsigned).
  - Responses are 3 cycles apart.
- Backpressure: after req1 (a=4'b0110, b=4'b0010) is accepted, hold rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_res=3'b010 stay stable; req_ready stays 0; busy stays 1.
  - On release, the next grant goes to req2 if it is valid.
- Reset mid-flight: assert rst_n=0 while in RESP.
  - rsp_valid falls without waiting for a clock edge.
  - After release the first grant goes to req0 (rr_ptr=0).
